// File: rtl/curtain_pkg.sv
// Shared definitions for the light-controlled curtain stepper controller:
// FSM encoding, direction constants and default parameter values.
package curtain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_AUTO_MOVE = 2'd1,
        ST_MANUAL    = 2'd2
    } state_t;

    localparam logic DIR_OPEN  = 1'b1;
    localparam logic DIR_CLOSE = 1'b0;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_SAMPLE_DIV     = 40_000_000;
    localparam int DEF_STEP_DIV       = 50_000;
    localparam int DEF_DEADBAND       = 4;
    localparam int DEF_STEPS_PER_MOVE = 64;
    localparam int DEF_MAX_POS        = 2048;

    localparam logic [3:0] PHASE_INIT = 4'b0001;

    // True when the travel limit in direction d has already been reached.
    function automatic logic limit_hit(input logic d, input logic at_open, input logic at_closed);
        return (d == DIR_OPEN) ? at_open : at_closed;
    endfunction

endpackage

// File: rtl/curtain_step_seq.sv
// Step divider, one-hot phase rotation and limited up/down position counter.
// Steps only while run is high; clr restarts the divider on a new move.
module curtain_step_seq
    import curtain_pkg::*;
#(
    parameter int STEP_DIV = DEF_STEP_DIV,
    parameter int MAX_POS  = DEF_MAX_POS,
    parameter int POS_W    = $clog2(MAX_POS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             dir,
    input  logic             clr,
    output logic             tick,
    output logic [3:0]       phase_reg,
    output logic [POS_W-1:0] pos,
    output logic             lim_open,
    output logic             lim_closed
);
    localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(MAX_POS);

    logic [DIV_W-1:0] div_reg;
    logic [POS_W-1:0] pos_reg;
    logic             blocked;

    assign pos        = pos_reg;
    assign lim_open   = (pos_reg == POS_MAX);
    assign lim_closed = (pos_reg == '0);

    // A tick that would run past either end stop is swallowed here as well,
    // so the counter can never wrap even if the FSM is a cycle late.
    assign blocked = limit_hit(dir, lim_open, lim_closed);
    assign tick    = run && !clr && (div_reg == DIV_LAST) && !blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg   <= '0;
            phase_reg <= PHASE_INIT;
            pos_reg   <= '0;
        end else begin
            if (!run || clr || (div_reg == DIV_LAST)) begin
                div_reg <= '0;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end

            if (tick) begin
                if (dir == DIR_OPEN) begin
                    phase_reg <= {phase_reg[2:0], phase_reg[3]};
                    pos_reg   <= pos_reg + POS_W'(1);
                end else begin
                    phase_reg <= {phase_reg[0], phase_reg[3:1]};
                    pos_reg   <= pos_reg - POS_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/curtain_step_ctrl.sv
// Curtain stepper controller top: periodic light sampling, deadband
// comparison of consecutive samples, and the IDLE/AUTO_MOVE/MANUAL FSM.
module curtain_step_ctrl
    import curtain_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SAMPLE_DIV     = DEF_SAMPLE_DIV,
    parameter int STEP_DIV       = DEF_STEP_DIV,
    parameter int DEADBAND       = DEF_DEADBAND,
    parameter int STEPS_PER_MOVE = DEF_STEPS_PER_MOVE,
    parameter int MAX_POS        = DEF_MAX_POS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         auto_en,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         man_open,
    input  logic                         man_close,
    output logic [3:0]                   phase,
    output logic [$clog2(MAX_POS+1)-1:0] pos,
    output logic                         moving,
    output logic                         dir,
    output logic                         lim_open,
    output logic                         lim_closed
);
    localparam int                    POS_W      = $clog2(MAX_POS + 1);
    localparam int                    SAMP_W     = $clog2(SAMPLE_DIV);
    localparam logic [SAMP_W-1:0]     SAMP_LAST  = SAMP_W'(SAMPLE_DIV - 1);
    localparam int                    STEP_CNT_W = $clog2(STEPS_PER_MOVE + 1);
    localparam logic [STEP_CNT_W-1:0] STEP_LOAD  = STEP_CNT_W'(STEPS_PER_MOVE);
    localparam logic signed [DATA_W:0] DB_POS    = (DATA_W + 1)'(DEADBAND);
    localparam logic signed [DATA_W:0] DB_NEG    = -DB_POS;

    state_t                  state_reg, state_next;
    logic                    dir_reg, dir_next;
    logic [STEP_CNT_W-1:0]   step_cnt_reg, step_cnt_next;
    logic [SAMP_W-1:0]       samp_cnt_reg;
    logic [DATA_W-1:0]       cur_reg, prev_reg;
    logic [1:0]              samples_reg;
    logic                    sample_vld_reg, fault_reg;
    logic signed [DATA_W:0]  diff;
    logic                    auto_req, req_dir, man_req, man_dir;
    logic                    run, clr, tick;
    logic [3:0]              phase_reg;

    // Free-running sample timer; samples_reg saturates at 2 so a decision
    // is only ever made from two real samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt_reg   <= '0;
            cur_reg        <= '0;
            prev_reg       <= '0;
            samples_reg    <= '0;
            sample_vld_reg <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            sample_vld_reg <= 1'b0;
            if (samp_cnt_reg == SAMP_LAST) begin
                samp_cnt_reg   <= '0;
                prev_reg       <= cur_reg;
                cur_reg        <= data_in;
                fault_reg      <= (data_in == '0);
                sample_vld_reg <= 1'b1;
                if (samples_reg != 2'd2) begin
                    samples_reg <= samples_reg + 2'd1;
                end
            end else begin
                samp_cnt_reg <= samp_cnt_reg + SAMP_W'(1);
            end
        end
    end

    assign diff     = $signed({1'b0, cur_reg}) - $signed({1'b0, prev_reg});
    assign auto_req = sample_vld_reg && (samples_reg == 2'd2) && !fault_reg
                      && ((diff > DB_POS) || (diff < DB_NEG));
    assign req_dir  = (diff > DB_POS) ? DIR_CLOSE : DIR_OPEN;
    assign man_req  = man_open ^ man_close;
    assign man_dir  = man_open ? DIR_OPEN : DIR_CLOSE;

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        step_cnt_next = step_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (man_req && !limit_hit(man_dir, lim_open, lim_closed)) begin
                    state_next = ST_MANUAL;
                    dir_next   = man_dir;
                end else if (auto_req && auto_en && !limit_hit(req_dir, lim_open, lim_closed)) begin
                    state_next    = ST_AUTO_MOVE;
                    dir_next      = req_dir;
                    step_cnt_next = STEP_LOAD;
                end
            end
            ST_AUTO_MOVE: begin
                if (man_req) begin
                    state_next = ST_MANUAL;
                    dir_next   = man_dir;
                end else if ((step_cnt_reg == '0) || limit_hit(dir_reg, lim_open, lim_closed)) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    step_cnt_next = step_cnt_reg - STEP_CNT_W'(1);
                end
            end
            ST_MANUAL: begin
                if (!man_req || limit_hit(man_dir, lim_open, lim_closed)) begin
                    state_next = ST_IDLE;
                end else begin
                    dir_next = man_dir;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            dir_reg      <= DIR_CLOSE;
            step_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            step_cnt_reg <= step_cnt_next;
        end
    end

    // Restart the step divider whenever a move starts or changes direction.
    assign run = (state_reg != ST_IDLE);
    assign clr = (state_next != ST_IDLE) && ((state_next != state_reg) || (dir_next != dir_reg));

    curtain_step_seq #(
        .STEP_DIV (STEP_DIV),
        .MAX_POS  (MAX_POS),
        .POS_W    (POS_W)
    ) u_step_seq (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .dir        (dir_reg),
        .clr        (clr),
        .tick       (tick),
        .phase_reg  (phase_reg),
        .pos        (pos),
        .lim_open   (lim_open),
        .lim_closed (lim_closed)
    );

    assign moving = run;
    assign dir    = dir_reg;
    assign phase  = run ? phase_reg : 4'b0000;

endmodule

// File: tb/tb_curtain_step_ctrl.sv
// Directed bench for curtain_step_ctrl with short timers; all expected
// values are hand-derived edge numbers counted from reset release.
module tb_curtain_step_ctrl;

    localparam int DATA_W         = 8;
    localparam int SAMPLE_DIV     = 16;
    localparam int STEP_DIV       = 4;
    localparam int DEADBAND       = 4;
    localparam int STEPS_PER_MOVE = 8;
    localparam int MAX_POS        = 20;
    localparam int POS_W          = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              auto_en = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              man_open = 1'b0;
    logic              man_close = 1'b0;
    logic [3:0]        phase;
    logic [POS_W-1:0]  pos;
    logic              moving, dir, lim_open, lim_closed;

    int edge_no = 0;
    int vectors = 0;
    int miscompares = 0;
    int mv_cnt = 0;

    curtain_step_ctrl #(
        .DATA_W         (DATA_W),
        .SAMPLE_DIV     (SAMPLE_DIV),
        .STEP_DIV       (STEP_DIV),
        .DEADBAND       (DEADBAND),
        .STEPS_PER_MOVE (STEPS_PER_MOVE),
        .MAX_POS        (MAX_POS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .auto_en    (auto_en),
        .data_in    (data_in),
        .man_open   (man_open),
        .man_close  (man_close),
        .phase      (phase),
        .pos        (pos),
        .moving     (moving),
        .dir        (dir),
        .lim_open   (lim_open),
        .lim_closed (lim_closed)
    );

    always #5 clk = ~clk;

    // Edge n is the n-th rising clock edge after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_no <= 0;
        else     edge_no <= edge_no + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    // Advance to the falling edge just after rising edge n.
    task automatic step_to(input int n);
        int guard;
        guard = 0;
        while (edge_no < n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("step_to_edge", edge_no, n);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        man_open  = 1'b0;
        man_close = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values, then a constant sensor level produces no motion
        repeat (2) @(negedge clk);
        check("rst_phase", phase, 4'b0000);
        check("rst_pos", pos, 0);
        check("rst_moving", moving, 0);
        check("rst_dir", dir, 0);
        check("rst_lim_closed", lim_closed, 1);
        check("rst_lim_open", lim_open, 0);
        rst     = 1'b0;
        auto_en = 1'b1;
        data_in = 8'd50;
        for (int s = 1; s <= 5; s++) begin
            step_to(16 * s + 2);
            check("const_no_move", moving, 0);
        end
        check("const_phase", phase, 4'b0000);
        check("const_pos", pos, 0);
        check("const_lim_closed", lim_closed, 1);

        // 50 -> 40: darker, open 8 steps
        do_reset();
        data_in = 8'd50;
        step_to(20);
        data_in = 8'd40;
        step_to(32);
        check("open_pre_moving", moving, 0);
        mv_cnt = 0;
        for (int n = 33; n <= 70; n++) begin
            step_to(n);
            if (moving) mv_cnt++;
            if (n == 33) begin
                check("open_entry_dir", dir, 1);
                check("open_entry_phase", phase, 4'b0001);
                check("open_entry_pos", pos, 0);
            end
            if (n == 37) begin
                check("open_step1_phase", phase, 4'b0010);
                check("open_step1_pos", pos, 1);
                check("open_step1_lim_closed", lim_closed, 0);
            end
            if (n == 41) begin
                check("open_step2_phase", phase, 4'b0100);
                check("open_step2_pos", pos, 2);
            end
            if (n == 65) check("open_last_pos", pos, 8);
            if (n == 66) begin
                check("open_end_phase", phase, 4'b0000);
                check("open_end_pos", pos, 8);
                check("open_end_dir", dir, 1);
                data_in = 8'd47;
            end
        end
        check("open_move_cycles", mv_cnt, 33);

        // 40 -> 47: brighter by 7, close back to 0
        step_to(81);
        check("close_entry_moving", moving, 1);
        check("close_entry_dir", dir, 0);
        check("close_entry_phase", phase, 4'b0001);
        step_to(85);
        check("close_step1_phase", phase, 4'b1000);
        check("close_step1_pos", pos, 7);
        step_to(113);
        check("close_last_pos", pos, 0);
        check("close_last_lim_closed", lim_closed, 1);
        step_to(114);
        check("close_end_moving", moving, 0);
        data_in = 8'd50;
        // 47 -> 50: inside deadband
        step_to(130);
        check("deadband_no_move", moving, 0);
        data_in = 8'd40;

        // Three open decisions: 0 -> 8 -> 16 -> 20 (limited)
        step_to(145);
        check("open2_moving", moving, 1);
        check("open2_dir", dir, 1);
        step_to(180);
        check("open2_end_pos", pos, 8);
        check("open2_end_moving", moving, 0);
        data_in = 8'd30;
        step_to(226);
        check("open3_end_pos", pos, 16);
        check("open3_end_moving", moving, 0);
        data_in = 8'd20;
        step_to(257);
        check("open4_limit_pos", pos, 20);
        check("open4_lim_open", lim_open, 1);
        check("open4_still_moving", moving, 1);
        step_to(258);
        check("open4_stop_moving", moving, 0);
        check("open4_stop_phase", phase, 4'b0000);
        step_to(260);
        data_in = 8'd10;
        step_to(274);
        check("at_limit_ignored_moving", moving, 0);
        check("at_limit_ignored_pos", pos, 20);
        data_in = 8'd20;

        // Close to 12, then open and abort with man_close
        step_to(289);
        check("close2_moving", moving, 1);
        check("close2_dir", dir, 0);
        step_to(322);
        check("close2_end_pos", pos, 12);
        check("close2_end_moving", moving, 0);
        data_in = 8'd10;
        step_to(337);
        check("open5_moving", moving, 1);
        check("open5_dir", dir, 1);
        step_to(346);
        check("open5_pos", pos, 14);
        man_close = 1'b1;
        step_to(347);
        check("abort_moving", moving, 1);
        check("abort_dir", dir, 0);
        check("abort_pos", pos, 14);
        step_to(351);
        check("manual_step1_pos", pos, 13);
        step_to(358);
        check("manual_step2_pos", pos, 12);
        man_close = 1'b0;
        step_to(359);
        check("manual_end_moving", moving, 0);
        check("manual_end_phase", phase, 4'b0000);
        check("manual_end_pos", pos, 11);

        // Both manual switches: no motion
        step_to(362);
        man_open  = 1'b1;
        man_close = 1'b1;
        step_to(364);
        check("both_man_moving", moving, 0);
        step_to(372);
        check("both_man_moving2", moving, 0);
        check("both_man_pos", pos, 11);
        man_open  = 1'b0;
        man_close = 1'b0;
        step_to(374);
        data_in = 8'd0;
        // Zero sample is a sensor fault: no open despite the drop
        step_to(386);
        check("fault_no_move", moving, 0);

        // Manual open, then asynchronous reset mid-move
        step_to(388);
        man_open = 1'b1;
        step_to(389);
        check("man_open_moving", moving, 1);
        check("man_open_dir", dir, 1);
        step_to(393);
        check("man_open_pos", pos, 12);
        #2 rst = 1'b1;
        #1;
        check("async_rst_phase", phase, 4'b0000);
        check("async_rst_pos", pos, 0);
        check("async_rst_moving", moving, 0);
        check("async_rst_dir", dir, 0);
        check("async_rst_lim_closed", lim_closed, 1);
        check("async_rst_lim_open", lim_open, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
